// File: rtl/chip8_alu_pkg.sv
// Shared definitions for the CHIP-8 8XYN arithmetic sequencer:
// ALU select codes, FSM state encoding and opcode classification helpers.
package chip8_alu_pkg;

   localparam logic [3:0] ALU_NONE = 4'h0;
   localparam logic [3:0] ALU_OR   = 4'h1;
   localparam logic [3:0] ALU_AND  = 4'h2;
   localparam logic [3:0] ALU_XOR  = 4'h3;
   localparam logic [3:0] ALU_ADD  = 4'h4;
   localparam logic [3:0] ALU_SUB  = 4'h5;
   localparam logic [3:0] ALU_SHL  = 4'h6;
   localparam logic [3:0] ALU_SHR  = 4'h7;
   localparam logic [3:0] ALU_LSB  = 4'hA;
   localparam logic [3:0] ALU_MSB  = 4'hB;

   localparam logic [3:0] OP_GROUP = 4'h8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_EXEC    = 3'd2,
      ST_FLAG    = 3'd3,
      ST_WB_RES  = 3'd4,
      ST_WB_FLAG = 3'd5,
      ST_DONE    = 3'd6
   } state_t;

   function automatic logic is_legal(input logic [15:0] op);
      logic n_ok;
      case (op[3:0])
         4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE: n_ok = 1'b1;
         default:                                              n_ok = 1'b0;
      endcase
      return (op[15:12] == OP_GROUP) && n_ok;
   endfunction

   // Shifts need an extra ALU pass to extract the bit shifted out.
   function automatic logic uses_flag_pass(input logic [3:0] n);
      return (n == 4'h6) || (n == 4'hE);
   endfunction

   function automatic logic writes_flag(input logic [3:0] n);
      case (n)
         4'h4, 4'h5, 4'h6, 4'h7, 4'hE: return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/chip8_alu_seq.sv
// Sequencer for CHIP-8 8XYN register/ALU instructions: reads Vx/Vy, drives an
// external ALU, then writes the result and (where defined) the VF flag.
module chip8_alu_seq
   import chip8_alu_pkg::*;
#(
   parameter logic [3:0] FLAG_REG = 4'hF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] opcode,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic [3:0]  rd_addr_a,
   output logic [3:0]  rd_addr_b,
   input  logic [7:0]  rd_data_a,
   input  logic [7:0]  rd_data_b,
   output logic        wr_en,
   output logic [3:0]  wr_addr,
   output logic [7:0]  wr_data,
   output logic [15:0] alu_in1,
   output logic [15:0] alu_in2,
   output logic [3:0]  alu_sel,
   input  logic [15:0] alu_out,
   input  logic        alu_carry
);

   state_t      state_r;
   state_t      state_nxt_s;
   logic [3:0]  x_r;
   logic [3:0]  y_r;
   logic [3:0]  n_r;
   logic [7:0]  vx_r;
   logic [7:0]  result_r;
   logic        flag_r;
   logic        illegal_r;
   logic        flag_exec_s;
   logic        unused_alu_hi_s;

   assign unused_alu_hi_s = ^alu_out[15:8];

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = is_legal(opcode) ? ST_READ : ST_DONE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_READ:    state_nxt_s = ST_EXEC;
         ST_EXEC:    state_nxt_s = uses_flag_pass(n_r) ? ST_FLAG : ST_WB_RES;
         ST_FLAG:    state_nxt_s = ST_WB_RES;
         ST_WB_RES:  state_nxt_s = writes_flag(n_r) ? ST_WB_FLAG : ST_DONE;
         ST_WB_FLAG: state_nxt_s = ST_DONE;
         ST_DONE:    state_nxt_s = ST_IDLE;
         default:    state_nxt_s = ST_IDLE;
      endcase
   end

   // Flag as known at the end of EXEC; shifts overwrite it in FLAG.
   always_comb begin
      flag_exec_s = flag_r;
      case (n_r)
         4'h4:    flag_exec_s = alu_carry;
         4'h5:    flag_exec_s = (rd_data_a >= rd_data_b);
         4'h7:    flag_exec_s = (rd_data_b >= rd_data_a);
         default: flag_exec_s = flag_r;
      endcase
   end

   // State register and operand/result latches.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         x_r       <= 4'h0;
         y_r       <= 4'h0;
         n_r       <= 4'h0;
         vx_r      <= 8'h00;
         result_r  <= 8'h00;
         flag_r    <= 1'b0;
         illegal_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  illegal_r <= !is_legal(opcode);
                  if (is_legal(opcode)) begin
                     x_r <= opcode[11:8];
                     y_r <= opcode[7:4];
                     n_r <= opcode[3:0];
                  end
               end
            end
            ST_EXEC: begin
               vx_r     <= rd_data_a;
               result_r <= (n_r == 4'h0) ? rd_data_b : alu_out[7:0];
               flag_r   <= flag_exec_s;
            end
            ST_FLAG: flag_r <= alu_out[0];
            default: ;
         endcase
      end
   end

   // Moore outputs decoded from the state register, so reset clears them at once.
   always_comb begin
      busy      = (state_r != ST_IDLE);
      done      = 1'b0;
      illegal   = 1'b0;
      rd_addr_a = 4'h0;
      rd_addr_b = 4'h0;
      wr_en     = 1'b0;
      wr_addr   = 4'h0;
      wr_data   = 8'h00;
      alu_sel   = ALU_NONE;
      alu_in1   = 16'h0000;
      alu_in2   = 16'h0000;
      case (state_r)
         ST_READ: begin
            rd_addr_a = x_r;
            rd_addr_b = y_r;
         end
         ST_EXEC: begin
            case (n_r)
               4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                  alu_sel = n_r;
                  alu_in1 = {8'h00, rd_data_a};
                  alu_in2 = {8'h00, rd_data_b};
               end
               4'h7: begin
                  alu_sel = ALU_SUB;
                  alu_in1 = {8'h00, rd_data_b};
                  alu_in2 = {8'h00, rd_data_a};
               end
               4'h6: begin
                  alu_sel = ALU_SHR;
                  alu_in1 = {8'h00, rd_data_a};
                  alu_in2 = 16'h0001;
               end
               4'hE: begin
                  alu_sel = ALU_SHL;
                  alu_in1 = {8'h00, rd_data_a};
                  alu_in2 = 16'h0001;
               end
               default: alu_sel = ALU_NONE;
            endcase
         end
         ST_FLAG: begin
            alu_sel = (n_r == 4'h6) ? ALU_LSB : ALU_MSB;
            alu_in1 = {8'h00, vx_r};
         end
         ST_WB_RES: begin
            wr_en   = 1'b1;
            wr_addr = x_r;
            wr_data = result_r;
         end
         ST_WB_FLAG: begin
            wr_en   = 1'b1;
            wr_addr = FLAG_REG;
            wr_data = {7'b0000000, flag_r};
         end
         ST_DONE: begin
            done    = 1'b1;
            illegal = illegal_r;
         end
         default: busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_chip8_alu_seq.sv
// Directed bench for chip8_alu_seq with a behavioural register file and ALU.
module tb_chip8_alu_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [15:0] opcode;
   logic        busy, done, illegal;
   logic [3:0]  rd_addr_a, rd_addr_b;
   logic [7:0]  rd_data_a = 8'h00;
   logic [7:0]  rd_data_b = 8'h00;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [15:0] alu_in1, alu_in2, alu_out, alu_sum;
   logic [3:0]  alu_sel;
   logic        alu_carry;

   logic [7:0]  rf [16];
   logic        pre_en = 1'b0;
   logic [3:0]  pre_addr = 4'h0;
   logic [7:0]  pre_data = 8'h00;
   int          wr_count = 0;
   int          done_count = 0;
   logic [3:0]  last_wr_addr = 4'h0;
   logic [7:0]  last_wr_data = 8'h00;

   int vectors = 0;
   int miscompares = 0;

   chip8_alu_seq dut (
      .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
      .busy(busy), .done(done), .illegal(illegal),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_carry(alu_carry)
   );

   always #5 clk = ~clk;

   // Register file: one-cycle read latency, bench preload port, write log.
   always @(posedge clk) begin
      rd_data_a <= rf[rd_addr_a];
      rd_data_b <= rf[rd_addr_b];
      if (pre_en) begin
         rf[pre_addr] <= pre_data;
      end else if (wr_en) begin
         rf[wr_addr]  <= wr_data;
         wr_count     <= wr_count + 1;
         last_wr_addr <= wr_addr;
         last_wr_data <= wr_data;
      end
      if (done) done_count <= done_count + 1;
   end

   // Reference ALU with 8-bit carry out of the add.
   always_comb begin
      alu_out   = 16'h0000;
      alu_carry = 1'b0;
      alu_sum   = alu_in1 + alu_in2;
      case (alu_sel)
         4'h1: alu_out = alu_in1 | alu_in2;
         4'h2: alu_out = alu_in1 & alu_in2;
         4'h3: alu_out = alu_in1 ^ alu_in2;
         4'h4: begin alu_out = alu_sum; alu_carry = alu_sum[8]; end
         4'h5: alu_out = alu_in1 - alu_in2;
         4'h6: alu_out = alu_in1 << alu_in2[3:0];
         4'h7: alu_out = alu_in1 >> alu_in2[3:0];
         4'hA: alu_out = {15'h0000, alu_in1[0]};
         4'hB: alu_out = {15'h0000, alu_in1[7]};
         default: alu_out = 16'h0000;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   // Issue one start and count negedges until done (0 means it never came).
   task automatic run_op(input logic [15:0] op, output int lat, output logic ill);
      @(negedge clk);
      opcode = op; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0; ill = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i; ill = illegal;
            break;
         end
      end
   endtask

   int   lat;
   logic ill;
   int   wr_before, done_before;

   initial begin
      reset_n = 1'b0; start = 1'b1; opcode = 16'h8124;
      repeat (3) @(negedge clk);
      check("reset_ctrl", 32'({busy, done, illegal, wr_en}), 32'h0);
      check("reset_wr", 32'({wr_addr, wr_data}), 32'h0);
      check("reset_rd", 32'({rd_addr_a, rd_addr_b}), 32'h0);
      check("reset_alu", 32'({alu_sel, alu_in1, alu_in2}), 32'h0);
      start = 1'b0;
      reset_n = 1'b1;

      // ADD with carry, latency 5
      preload(4'h1, 8'hF0); preload(4'h2, 8'h20); preload(4'hF, 8'h00);
      wr_before = wr_count;
      run_op(16'h8124, lat, ill);
      check("add_lat", 32'(lat), 32'd5);
      check("add_ill", 32'(ill), 32'd0);
      check("add_v1", 32'(rf[1]), 32'h10);
      check("add_vf", 32'(rf[15]), 32'h01);
      check("add_writes", 32'(wr_count - wr_before), 32'd2);

      // SUB with borrow
      preload(4'h3, 8'h05); preload(4'h4, 8'h07); preload(4'hF, 8'h55);
      run_op(16'h8345, lat, ill);
      check("sub_lat", 32'(lat), 32'd5);
      check("sub_v3", 32'(rf[3]), 32'hFE);
      check("sub_vf", 32'(rf[15]), 32'h00);

      // SUBN
      preload(4'h3, 8'h07); preload(4'h4, 8'h05); preload(4'hF, 8'h55);
      run_op(16'h8347, lat, ill);
      check("subn_lat", 32'(lat), 32'd5);
      check("subn_v3", 32'(rf[3]), 32'hFE);
      check("subn_vf", 32'(rf[15]), 32'h00);

      // Shift left then shift right, latency 6
      preload(4'h5, 8'h81); preload(4'hF, 8'h00);
      run_op(16'h856E, lat, ill);
      check("shl_lat", 32'(lat), 32'd6);
      check("shl_v5", 32'(rf[5]), 32'h02);
      check("shl_vf", 32'(rf[15]), 32'h01);
      preload(4'h5, 8'h81); preload(4'hF, 8'h00);
      run_op(16'h8566, lat, ill);
      check("shr_lat", 32'(lat), 32'd6);
      check("shr_v5", 32'(rf[5]), 32'h40);
      check("shr_vf", 32'(rf[15]), 32'h01);

      // Logic ops and load: single write, VF untouched, latency 4
      preload(4'h1, 8'h0C); preload(4'h2, 8'h30); preload(4'hF, 8'h55);
      wr_before = wr_count;
      run_op(16'h8121, lat, ill);
      check("or_lat", 32'(lat), 32'd4);
      check("or_v1", 32'(rf[1]), 32'h3C);
      check("or_vf", 32'(rf[15]), 32'h55);
      check("or_writes", 32'(wr_count - wr_before), 32'd1);
      run_op(16'h8122, lat, ill);
      check("and_v1", 32'(rf[1]), 32'h30);
      preload(4'h2, 8'h5A);
      run_op(16'h8123, lat, ill);
      check("xor_v1", 32'(rf[1]), 32'h6A);
      run_op(16'h8120, lat, ill);
      check("ld_lat", 32'(lat), 32'd4);
      check("ld_v1", 32'(rf[1]), 32'h5A);

      // VF as destination: flag write lands last
      preload(4'hF, 8'hFF); preload(4'h0, 8'h01);
      run_op(16'h8F04, lat, ill);
      check("vfdst_vf", 32'(rf[15]), 32'h01);
      check("vfdst_last", 32'({last_wr_addr, last_wr_data}), 32'hF01);

      // Illegal opcodes: one cycle, no write
      wr_before = wr_count;
      run_op(16'h8128, lat, ill);
      check("ill_lat", 32'(lat), 32'd1);
      check("ill_flag", 32'(ill), 32'd1);
      run_op(16'h9120, lat, ill);
      check("ill_grp_flag", 32'({lat[7:0], 7'h00, ill}), 32'h0101);
      check("ill_writes", 32'(wr_count - wr_before), 32'd0);
      run_op(16'h8121, lat, ill);
      check("after_ill_flag", 32'(ill), 32'd0);

      // Start while busy is ignored
      preload(4'h1, 8'hF0); preload(4'h2, 8'h20); preload(4'h5, 8'h77); preload(4'hF, 8'h00);
      wr_before = wr_count; done_before = done_count;
      @(negedge clk); opcode = 16'h8124; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk); opcode = 16'h8550; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (12) @(negedge clk);
      check("busy_dones", 32'(done_count - done_before), 32'd1);
      check("busy_writes", 32'(wr_count - wr_before), 32'd2);
      check("busy_v1", 32'(rf[1]), 32'h10);
      check("busy_v5", 32'(rf[5]), 32'h77);

      // Reset in WB_RES: write strobe drops asynchronously, no done
      preload(4'h1, 8'h0C); preload(4'h2, 8'h30);
      wr_before = wr_count; done_before = done_count;
      @(negedge clk); opcode = 16'h8121; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      check("wbres_wr_en", 32'(wr_en), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("rst_async", 32'({wr_en, busy, done}), 32'h0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_writes", 32'(wr_count - wr_before), 32'd0);
      check("rst_dones", 32'(done_count - done_before), 32'd0);
      check("rst_v1", 32'(rf[1]), 32'h0C);
      run_op(16'h8121, lat, ill);
      check("post_rst_lat", 32'(lat), 32'd4);
      check("post_rst_v1", 32'(rf[1]), 32'h3C);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
